// File: rtl/if_fetch_stage_pkg.sv
// Shared fetch-stage types and constants.
package if_fetch_stage_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        HOLD    = 2'd2,
        DISCARD = 2'd3
    } fetch_state_t;

    localparam logic [31:0] PC_STEP   = 32'd4;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/if_fetch_stage_pc_reg.sv
// Program counter with reset > redirect > increment priority.
module if_fetch_stage_pc_reg
    import if_fetch_stage_pkg::*;
#(
    parameter int          DATA_W   = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              redirect,
    input  logic [DATA_W-1:0] target,
    input  logic              increment,
    output logic [DATA_W-1:0] pc
);

    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= DATA_W'(RESET_PC);
        end else if (redirect) begin
            pc <= target;
        end else if (increment) begin
            pc <= pc + DATA_W'(PC_STEP);
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, talks to imem and drives the IF/ID register.
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DATA_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [DATA_W-1:0] branch_target,
    output logic              imem_req,
    output logic [DATA_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [DATA_W-1:0] instruction,
    output logic [DATA_W-1:0] pc_out,
    output logic              if_id_load_enable,
    output logic              if_id_reset
);

    fetch_state_t      state, state_n;
    logic [DATA_W-1:0] pc, pc_plus, target;
    logic [DATA_W-1:0] hold_buf, hold_buf_n;
    logic [DATA_W-1:0] redirect_pc, redirect_pc_n;
    logic [DATA_W-1:0] addr_n, instr_n, pc_out_n, pc_target;
    logic              req_n, load_n, flush_n;
    logic              pc_redirect, pc_inc;

    assign target  = {branch_target[DATA_W-1:2], 2'b00};
    assign pc_plus = pc + DATA_W'(PC_STEP);

    if_fetch_stage_pc_reg #(
        .DATA_W   (DATA_W),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk       (clk),
        .reset     (reset),
        .redirect  (pc_redirect),
        .target    (pc_target),
        .increment (pc_inc),
        .pc        (pc)
    );

    always_comb begin
        state_n       = state;
        req_n         = imem_req;
        addr_n        = imem_addr;
        instr_n       = instruction;
        pc_out_n      = pc_out;
        hold_buf_n    = hold_buf;
        redirect_pc_n = redirect_pc;
        load_n        = 1'b1;
        flush_n       = 1'b1;
        pc_redirect   = 1'b0;
        pc_inc        = 1'b0;
        pc_target     = target;

        case (state)
            IDLE: begin
                req_n   = 1'b1;
                state_n = FETCH;
                if (branch_taken) begin
                    pc_redirect = 1'b1;
                    addr_n      = target;
                end else begin
                    addr_n = pc;
                    if (stall) begin
                        load_n  = 1'b0;
                        flush_n = 1'b0;
                    end
                end
            end
            FETCH: begin
                if (!imem_ready) begin
                    if (branch_taken) begin
                        redirect_pc_n = target;
                        state_n       = DISCARD;
                    end else if (stall) begin
                        load_n  = 1'b0;
                        flush_n = 1'b0;
                    end
                end else if (branch_taken) begin
                    pc_redirect = 1'b1;
                    addr_n      = target;
                end else if (stall) begin
                    // Word is parked so the request can be dropped while ID is stalled.
                    hold_buf_n = imem_rdata;
                    pc_inc     = 1'b1;
                    req_n      = 1'b0;
                    state_n    = HOLD;
                    load_n     = 1'b0;
                    flush_n    = 1'b0;
                end else begin
                    instr_n  = imem_rdata;
                    pc_out_n = pc;
                    pc_inc   = 1'b1;
                    addr_n   = pc_plus;
                    flush_n  = 1'b0;
                end
            end
            HOLD: begin
                if (branch_taken) begin
                    hold_buf_n  = DATA_W'(NOP_INSTR);
                    pc_redirect = 1'b1;
                    state_n     = IDLE;
                end else if (stall) begin
                    load_n  = 1'b0;
                    flush_n = 1'b0;
                end else begin
                    instr_n  = hold_buf;
                    pc_out_n = pc - DATA_W'(PC_STEP);
                    flush_n  = 1'b0;
                    state_n  = IDLE;
                end
            end
            DISCARD: begin
                if (branch_taken) begin
                    redirect_pc_n = target;
                end
                // The latest redirect wins even when it arrives with the stale word.
                if (imem_ready) begin
                    pc_redirect = 1'b1;
                    pc_target   = branch_taken ? target : redirect_pc;
                    addr_n      = pc_target;
                    req_n       = 1'b1;
                    state_n     = FETCH;
                end
                if (stall && !branch_taken) begin
                    load_n  = 1'b0;
                    flush_n = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            imem_req          <= 1'b0;
            imem_addr         <= DATA_W'(RESET_PC);
            instruction       <= DATA_W'(NOP_INSTR);
            pc_out            <= '0;
            if_id_load_enable <= 1'b1;
            if_id_reset       <= 1'b1;
            hold_buf          <= '0;
            redirect_pc       <= '0;
        end else begin
            state             <= state_n;
            imem_req          <= req_n;
            imem_addr         <= addr_n;
            instruction       <= instr_n;
            pc_out            <= pc_out_n;
            if_id_load_enable <= load_n;
            if_id_reset       <= flush_n;
            hold_buf          <= hold_buf_n;
            redirect_pc       <= redirect_pc_n;
        end
    end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
Instruction-fetch stage that sits directly upstream of the IF/ID pipeline register. It owns the PC and issues requests to a variable-latency instruction memory over a req/ready handshake. It drives the IF/ID register's instruction, load_enable and reset (flush) inputs every cycle. Each cycle the IF/ID register receives exactly one of: a new instruction, a bubble (flush), or a hold (stall).

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
DATA_W, 32, instruction and address width.

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
stall  in  1  hazard-unit stall; IF/ID must hold
branch_taken  in  1  redirect request from EXE; one-cycle pulse
branch_target  in  32  redirect PC, valid with branch_taken
imem_req  out  1  fetch request; held high until imem_ready
imem_addr  out  32  fetch address; stable while imem_req=1 and imem_ready=0
imem_ready  in  1  memory returns imem_rdata this cycle
imem_rdata  in  32  fetched word
instruction  out  32  to IF/ID instruction input
pc_out  out  32  address of the word on the instruction output
if_id_load_enable  out  1  to IF/ID load_enable
if_id_reset  out  1  to IF/ID reset (1 = bubble)

Behaviour:
- Single clock. Reset is synchronous and active-high. All outputs are registered; IF/ID samples them on the following edge.
- Reset values: pc=RESET_PC, state=IDLE, imem_req=0, imem_addr=RESET_PC, instruction=0, pc_out=0, if_id_load_enable=1, if_id_reset=1, hold_buf=0, redirect_pc=0.
- Event priority each edge: reset > branch_taken > stall > normal.
- Output rule: deliver → load_en=1, reset=0. Bubble → load_en=1, reset=1. Hold → load_en=0 (instruction and pc_out unchanged).
- IDLE: assert imem_req with imem_addr=pc; go to FETCH. Output a bubble.
- FETCH, imem_ready=0:
  - branch_taken: redirect_pc<=branch_target, go to DISCARD. Keep req and addr unchanged. Output a bubble.
  - otherwise: output hold if stall=1, else a bubble.
- FETCH, imem_ready=1:
  - branch_taken: drop rdata, pc<=branch_target, imem_addr<=branch_target, req stays 1. Output a bubble.
  - stall: hold_buf<=rdata, pc<=pc+4, imem_req<=0, go to HOLD. Output hold.
  - else: instruction<=rdata, pc_out<=pc, pc<=pc+4, imem_addr<=pc+4, req stays 1. Output deliver. Back-to-back delivery at one word per cycle with zero-wait memory.
- HOLD, imem_req=0:
  - branch_taken: discard hold_buf, pc<=branch_target, go to IDLE. Output a bubble.
  - stall=1: output hold.
  - stall=0: instruction<=hold_buf, pc_out<=pc-4, output deliver, go to IDLE.
- DISCARD (request to the old address still outstanding):
  - a further branch_taken overwrites redirect_pc (latest wins).
  - on imem_ready: drop rdata, pc<=redirect_pc, imem_addr<=redirect_pc, go to FETCH with req=1.
  - every DISCARD cycle outputs a bubble, or a hold if stall=1 and no branch.
- PC arithmetic is modulo 2^32; 0xFFFF_FFFC+4 wraps to 0. branch_target bits[1:0] are forced to 0.
- Reset mid-transaction abandons any outstanding request. Memory must tolerate imem_req dropping before imem_ready.

Decomposition:
- Shared pipeline package: FETCH_STATE_T enum (IDLE, FETCH, HOLD, DISCARD), PC_STEP=4, NOP_INSTR=0.
- Sub-module pc_reg holds the PC with load/increment/redirect priority (reset > redirect > increment). The FSM stays in the top-level module.

Test Plan:
1. Reset 2 cycles, imem_ready tied 1, rdata=addr^32'hE000_0000 → imem_addr 0x0,0x4,0x8 on consecutive cycles; instruction=0xE000_0000,0xE000_0004 with load_en=1, if_id_reset=0 each cycle.
2. imem_ready delayed 3 cycles on addr 0x0 → imem_req=1 and addr=0x0 held for 3 cycles with bubbles output; then instruction=rdata, pc_out=0x0.
3. stall=1 for 2 cycles at the capture of 0xE3A01005 → load_en=0 and imem_req=0 for 2 cycles; then instruction=0xE3A01005, pc_out=0x0, next imem_addr=0x4.
4. branch_taken, target 0x100, while addr 0x8 is outstanding → DISCARD; returned word dropped with a bubble output; next imem_addr=0x100, first delivery pc_out=0x100.
5. branch_taken (target 0x40) and stall in the same cycle as imem_ready → bubble output, not hold; imem_addr=0x40.
6. reset asserted mid-FETCH at addr 0xC → next cycle all outputs at reset values; after release first imem_addr=RESET_PC.
